// File: rtl/rect_fill_writer.sv
// Rectangle fill command to per-pixel frame-buffer write stream, one pixel per cycle.
// Optional screen clipping is enabled by defining RECT_CLIP_EN.
//
// state | meaning
// IDLE  | ready for a command
// FILL  | emitting pixel writes for the latched rectangle
// FIN   | one-cycle DONE pulse, then back to IDLE
module rect_fill_writer #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 24,
    parameter int COORD_W = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [COORD_W-1:0] CMD_X,
    input  logic [COORD_W-1:0] CMD_Y,
    input  logic [COORD_W-1:0] CMD_W,
    input  logic [COORD_W-1:0] CMD_H,
    input  logic [DATA_W-1:0]  CMD_COLOR,
    output logic               WRITE_EN,
    input  logic               WRITE_STALL,
    output logic [ADDR_W-1:0]  WRITE_ADDR,
    output logic [DATA_W-1:0]  WRITE_DATA,
    output logic               BUSY,
    output logic               DONE
);

    // A visible frame must fit the write address space.
    if (H_RES * V_RES > (1 << ADDR_W)) begin : g_cfg_check
        $error("rect_fill_writer: H_RES*V_RES exceeds the ADDR_W address space");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FIN
    } state_t;

    localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1);
    localparam logic [ADDR_W-1:0]  PITCH = ADDR_W'(H_RES);

    state_t             state, state_n;
    logic [COORD_W-1:0] col, col_n, row, row_n;
    logic [COORD_W-1:0] w_r, w_n, h_r, h_n;
    logic [COORD_W-1:0] w_eff, h_eff;
    logic [ADDR_W-1:0]  row_base, row_base_n, addr_n;
    logic [DATA_W-1:0]  data_n;
    logic               en_n, done_n;
    logic               accept, consume;

`ifdef RECT_CLIP_EN
    localparam int CW1 = COORD_W + 1;
    logic [CW1-1:0] x_ext, y_ext, x_end, y_end, w_clip, h_clip;

    // One extra bit so x+w cannot wrap before the compare against the screen edge.
    always_comb begin
        x_ext = CW1'(CMD_X);
        y_ext = CW1'(CMD_Y);
        x_end = x_ext + CW1'(CMD_W);
        y_end = y_ext + CW1'(CMD_H);
        if (x_ext >= CW1'(H_RES))
            w_clip = '0;
        else if (x_end > CW1'(H_RES))
            w_clip = CW1'(H_RES) - x_ext;
        else
            w_clip = CW1'(CMD_W);
        if (y_ext >= CW1'(V_RES))
            h_clip = '0;
        else if (y_end > CW1'(V_RES))
            h_clip = CW1'(V_RES) - y_ext;
        else
            h_clip = CW1'(CMD_H);
        w_eff = COORD_W'(w_clip);
        h_eff = COORD_W'(h_clip);
    end
`else
    assign w_eff = CMD_W;
    assign h_eff = CMD_H;
`endif

    assign CMD_READY = (state == S_IDLE) && !RST;
    assign BUSY      = (state != S_IDLE);
    assign accept    = CMD_READY && CMD_VALID;
    assign consume   = WRITE_EN && !WRITE_STALL;

    always_comb begin
        state_n    = state;
        col_n      = col;
        row_n      = row;
        w_n        = w_r;
        h_n        = h_r;
        row_base_n = row_base;
        addr_n     = WRITE_ADDR;
        data_n     = WRITE_DATA;
        en_n       = WRITE_EN;
        done_n     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    data_n     = CMD_COLOR;
                    w_n        = w_eff;
                    h_n        = h_eff;
                    col_n      = '0;
                    row_n      = '0;
                    row_base_n = ADDR_W'(CMD_Y) * PITCH + ADDR_W'(CMD_X);
                    addr_n     = row_base_n;
                    if (w_eff == '0 || h_eff == '0) begin
                        state_n = S_FIN;
                        en_n    = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_FILL;
                        en_n    = 1'b1;
                    end
                end
            end
            S_FILL: begin
                // Everything advances only when the sink takes the pixel.
                if (consume) begin
                    if (col == w_r - ONE_C) begin
                        col_n = '0;
                        if (row == h_r - ONE_C) begin
                            state_n = S_FIN;
                            en_n    = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            row_n      = row + ONE_C;
                            row_base_n = row_base + PITCH;
                            addr_n     = row_base_n;
                        end
                    end else begin
                        col_n  = col + ONE_C;
                        addr_n = row_base + ADDR_W'(col_n);
                    end
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                en_n    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            col        <= '0;
            row        <= '0;
            w_r        <= '0;
            h_r        <= '0;
            row_base   <= '0;
            WRITE_EN   <= 1'b0;
            WRITE_ADDR <= '0;
            WRITE_DATA <= '0;
            DONE       <= 1'b0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            w_r        <= w_n;
            h_r        <= h_n;
            row_base   <= row_base_n;
            WRITE_EN   <= en_n;
            WRITE_ADDR <= addr_n;
            WRITE_DATA <= data_n;
            DONE       <= done_n;
        end
    end

endmodule
